rect_fill_engine: RTL and testbench

Parametrised rectangle painter for the VGA plot path. On Start it rasterises a RECT_W x RECT_H block at one of NUM_POS preset character lanes and emits one pixel per clock (X, Y, Color, Plot) into the frame-buffer write port. Erase mode paints the background colour; Fill mode paints a caller-supplied colour. It replaces fixed-size, fixed-lane erase logic and serves both character draw and erase.

---
 rtl/rect_fill_pkg.sv | 19 +
 rtl/rect_scan_counter.sv | 56 +++++
 rtl/rect_fill_engine.sv | 141 ++++++++++++++
 tb/tb_rect_fill_engine.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rect_fill_pkg.sv
// Shared constants and types for the rectangle painter: lane X table, screen size, FSM states.
package rect_fill_pkg;

  localparam int NUM_LANES = 4;
  localparam int POS_BITS  = $clog2(NUM_LANES);
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;

  // Entry i is the left edge of character lane i.
  localparam logic [NUM_LANES-1:0][7:0] LANE_X = {8'd132, 8'd78, 8'd24, 8'd6};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAW,
    DONE
  } state_e;

endpackage

// File: rtl/rect_scan_counter.sv
// Raster position counter: X inner, Y outer, wraps to (0,0) after (W-1,H-1).
// Clear wins over enable; Last_o flags the final pixel of the block.
module rect_scan_counter #(
  parameter int W = 9,
  parameter int H = 5
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Clear_i,
  input  logic                       En_i,
  output logic [$clog2(W+1)-1:0]     XCnt_o,
  output logic [$clog2(H+1)-1:0]     YCnt_o,
  output logic                       Last_o
);

  localparam int XW = $clog2(W+1);
  localparam int YW = $clog2(H+1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end, y_end;

  assign x_end = (x_q == XW'(W-1));
  assign y_end = (y_q == YW'(H-1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (Clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (En_i) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign XCnt_o = x_q;
  assign YCnt_o = y_q;
  assign Last_o = x_end && y_end;

endmodule

// File: rtl/rect_fill_engine.sv
// Paints a RECT_W x RECT_H block at a preset lane, one registered pixel per clock.
// Define RECT_FILL_CLIP_EN to suppress Plot for pixels outside the visible screen.
module rect_fill_engine
  import rect_fill_pkg::*;
#(
  parameter int                    RECT_W     = 9,
  parameter int                    RECT_H     = 5,
  parameter int                    NUM_POS    = 4,
  parameter int                    BASE_Y     = 102,
  parameter int                    X_BITS     = 8,
  parameter int                    Y_BITS     = 7,
  parameter int                    COLOR_BITS = 3,
  parameter logic [COLOR_BITS-1:0] BG_COLOR   = 3'b111
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [POS_BITS-1:0]   Pos,
  input  logic                  Erase,
  input  logic [COLOR_BITS-1:0] FillColor,
  output logic [X_BITS-1:0]     XOut,
  output logic [Y_BITS-1:0]     YOut,
  output logic [COLOR_BITS-1:0] Color,
  output logic                  Plot,
  output logic                  Busy,
  output logic                  Done,
  output logic                  PosErr
);

  localparam int XW = $clog2(RECT_W+1);
  localparam int YW = $clog2(RECT_H+1);

  state_e                  state_q, state_d;
  logic [POS_BITS-1:0]     pos_q;
  logic [COLOR_BITS-1:0]   paint_q;
  logic                    err_q;
  logic [X_BITS-1:0]       base_x_q;
  logic                    busy_q, done_q, perr_q, plot_q;
  logic [X_BITS-1:0]       xout_q;
  logic [Y_BITS-1:0]       yout_q;
  logic [COLOR_BITS-1:0]   color_q;

  logic [XW-1:0]           xcnt;
  logic [YW-1:0]           ycnt;
  logic                    last_px, cnt_clr, cnt_en;
  logic                    accept, pos_bad, on_screen;
  logic [X_BITS:0]         sum_x;
  logic [Y_BITS:0]         sum_y;

  // Busy is still high during the Done cycle, so a Start there is dropped.
  assign accept  = (state_q == IDLE) && Start && !busy_q;
  assign pos_bad = int'(Pos) >= NUM_POS;

  assign sum_x = (X_BITS+1)'(base_x_q) + (X_BITS+1)'(xcnt);
  assign sum_y = (Y_BITS+1)'(BASE_Y) + (Y_BITS+1)'(ycnt);

`ifdef RECT_FILL_CLIP_EN
  assign on_screen = (sum_x <= (X_BITS+1)'(SCREEN_W-1)) &&
                     (sum_y <= (Y_BITS+1)'(SCREEN_H-1));
`else
  assign on_screen = 1'b1;
`endif

  rect_scan_counter #(
    .W (RECT_W),
    .H (RECT_H)
  ) u_scan (
    .Clock   (Clock),
    .Reset   (Reset),
    .Clear_i (cnt_clr),
    .En_i    (cnt_en),
    .XCnt_o  (xcnt),
    .YCnt_o  (ycnt),
    .Last_o  (last_px)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = pos_bad ? DONE : LOAD;
      LOAD: begin
        cnt_clr = 1'b1;
        state_d = DRAW;
      end
      DRAW: begin
        cnt_en = 1'b1;
        if (last_px) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pos_q    <= '0;
      paint_q  <= '0;
      err_q    <= 1'b0;
      base_x_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      plot_q   <= 1'b0;
      xout_q   <= '0;
      yout_q   <= '0;
      color_q  <= '0;
    end else begin
      busy_q <= (state_q != IDLE) || accept;
      done_q <= (state_q == DONE);
      perr_q <= (state_q == DONE) && err_q;
      plot_q <= (state_q == DRAW) && on_screen;
      if (accept) begin
        pos_q   <= Pos;
        paint_q <= Erase ? BG_COLOR : FillColor;
        err_q   <= pos_bad;
      end
      if (state_q == LOAD) base_x_q <= X_BITS'(LANE_X[pos_q]);
      if (state_q == DRAW) begin
        xout_q  <= sum_x[X_BITS-1:0];
        yout_q  <= sum_y[Y_BITS-1:0];
        color_q <= paint_q;
      end
    end
  end

  assign XOut   = xout_q;
  assign YOut   = yout_q;
  assign Color  = color_q;
  assign Plot   = plot_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign PosErr = perr_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench: default 9x5 engine, a 16x16 engine with 3 lanes, and a 16x16 engine near the screen edge.
module tb_rect_fill_engine;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Instance A: default parameters
  logic       start_a = 1'b0, erase_a = 1'b0;
  logic [1:0] pos_a = 2'd0;
  logic [2:0] fill_a = 3'd0, ca;
  logic [7:0] xa;
  logic [6:0] ya;
  logic       plot_a, busy_a, done_a, perr_a;

  rect_fill_engine u_a (
    .Clock(Clock), .Reset(Reset), .Start(start_a), .Pos(pos_a), .Erase(erase_a),
    .FillColor(fill_a), .XOut(xa), .YOut(ya), .Color(ca), .Plot(plot_a),
    .Busy(busy_a), .Done(done_a), .PosErr(perr_a)
  );

  // Instance B: 16x16, only three lanes valid
  logic       start_b = 1'b0, erase_b = 1'b1;
  logic [1:0] pos_b = 2'd3;
  logic [2:0] fill_b = 3'd0, cb;
  logic [7:0] xb;
  logic [6:0] yb;
  logic       plot_b, busy_b, done_b, perr_b;

  rect_fill_engine #(.RECT_W(16), .RECT_H(16), .NUM_POS(3)) u_b (
    .Clock(Clock), .Reset(Reset), .Start(start_b), .Pos(pos_b), .Erase(erase_b),
    .FillColor(fill_b), .XOut(xb), .YOut(yb), .Color(cb), .Plot(plot_b),
    .Busy(busy_b), .Done(done_b), .PosErr(perr_b)
  );

  // Instance C: 16x16 starting at Y=117, rows run past the screen bottom and the 7-bit range
  logic       start_c = 1'b0, erase_c = 1'b0;
  logic [1:0] pos_c = 2'd3;
  logic [2:0] fill_c = 3'b011, cc;
  logic [7:0] xc;
  logic [6:0] yc;
  logic       plot_c, busy_c, done_c, perr_c;

  rect_fill_engine #(.RECT_W(16), .RECT_H(16), .NUM_POS(4), .BASE_Y(117)) u_c (
    .Clock(Clock), .Reset(Reset), .Start(start_c), .Pos(pos_c), .Erase(erase_c),
    .FillColor(fill_c), .XOut(xc), .YOut(yc), .Color(cc), .Plot(plot_c),
    .Busy(busy_c), .Done(done_c), .PosErr(perr_c)
  );

  // Cycle c is sampled on the falling edge after Start-sampling edge + (c-1).
  task automatic sweep_a(input logic [1:0] pos, input logic erase, input logic [2:0] fill,
                         input int bx, input int col, input bit inject);
    int n, first_c, last_c, done_n, done_at, perr_n;
    n = 0; first_c = -1; last_c = -1; done_n = 0; done_at = -1; perr_n = 0;
    @(negedge Clock);
    start_a = 1'b1; pos_a = pos; erase_a = erase; fill_a = fill;
    @(posedge Clock);
    @(negedge Clock);
    start_a = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (c > 1) @(negedge Clock);
      if (inject && c == 10) begin
        start_a = 1'b1; pos_a = 2'd1; erase_a = 1'b0; fill_a = 3'b001;
      end
      if (inject && c == 12) start_a = 1'b0;
      if (c == 1) check("busy_on_accept", busy_a, 1);
      if (plot_a) begin
        check("px_x", xa, bx + n % 9);
        check("px_y", ya, 102 + n / 9);
        check("px_color", ca, col);
        if (n == 0) first_c = c;
        last_c = c;
        n++;
      end
      if (done_a) begin done_n++; done_at = c; end
      if (perr_a) perr_n++;
      if (c == 48) check("busy_in_done", busy_a, 1);
      if (c == 49) check("busy_after_done", busy_a, 0);
    end
    check("pixel_count", n, 45);
    check("first_plot_cycle", first_c, 3);
    check("last_plot_cycle", last_c, 47);
    check("done_count", done_n, 1);
    check("done_cycle", done_at, 48);
    check("poserr_count", perr_n, 0);
    check("x_hold", xa, bx + 8);
    check("y_hold", ya, 106);
  endtask

  initial begin
    int n, done_n, done_at, n_low, first_x, first_y, last_x, last_y;

    repeat (3) @(negedge Clock);
    check("rst_x", xa, 0);
    check("rst_y", ya, 0);
    check("rst_color", ca, 0);
    check("rst_plot", plot_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_poserr", perr_a, 0);
    Reset = 1'b1;
    @(negedge Clock);

    // Erase at lane 0, fill at lane 3, then Start re-issued mid-draw
    sweep_a(2'd0, 1'b1, 3'b000, 6, 7, 1'b0);
    sweep_a(2'd3, 1'b0, 3'b010, 132, 2, 1'b0);
    sweep_a(2'd0, 1'b1, 3'b101, 6, 7, 1'b1);

    // Reset asserted while the 10th pixel is on the port
    @(negedge Clock);
    start_a = 1'b1; pos_a = 2'd2; erase_a = 1'b0; fill_a = 3'b100;
    @(posedge Clock);
    @(negedge Clock);
    start_a = 1'b0;
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge Clock);
      if (plot_a) n++;
    end
    check("rst_mid_plot10", plot_a, 1);
    check("rst_mid_count", n, 10);
    Reset = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    check("rst_mid_plot", plot_a, 0);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_x", xa, 0);
    Reset = 1'b1;
    n = 0; done_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (plot_a) n++;
      if (done_a) done_n++;
    end
    check("rst_mid_no_plot", n, 0);
    check("rst_mid_no_done", done_n, 0);
    sweep_a(2'd1, 1'b0, 3'b110, 24, 6, 1'b0);

    // Out-of-range lane on the 3-lane engine
    @(negedge Clock);
    start_b = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    start_b = 1'b0;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge Clock);
      if (plot_b) n++;
      if (c == 1) begin
        check("perr_c1_busy", busy_b, 1);
        check("perr_c1_done", done_b, 0);
      end
      if (c == 2) begin
        check("perr_c2_done", done_b, 1);
        check("perr_c2_poserr", perr_b, 1);
      end
      if (c == 3) begin
        check("perr_c3_done", done_b, 0);
        check("perr_c3_poserr", perr_b, 0);
        check("perr_c3_busy", busy_b, 0);
      end
    end
    check("perr_no_plot", n, 0);

    // Block crossing the screen bottom: clipped or wrapped depending on build
    @(negedge Clock);
    start_c = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    start_c = 1'b0;
    n = 0; n_low = 0; done_at = -1;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    for (int c = 1; c <= 270; c++) begin
      if (c > 1) @(negedge Clock);
      if (plot_c) begin
        if (n == 0) begin first_x = xc; first_y = yc; end
        last_x = xc; last_y = yc;
        if (yc < 117) n_low++;
        n++;
      end
      if (done_c) done_at = c;
    end
    check("edge_first_x", first_x, 132);
    check("edge_first_y", first_y, 117);
    check("edge_done_cycle", done_at, 259);
    check("edge_color", cc, 3);
`ifdef RECT_FILL_CLIP_EN
    check("clip_count", n, 48);
    check("clip_low_rows", n_low, 0);
    check("clip_last_x", last_x, 147);
    check("clip_last_y", last_y, 119);
`else
    check("wrap_count", n, 256);
    check("wrap_low_rows", n_low, 80);
    check("wrap_last_x", last_x, 147);
    check("wrap_last_y", last_y, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
